// File: rtl/switch_pkg.sv
//==============================================================================
// Module      : switch_pkg
// Description : Shared constants and types for the DIP-switch debounce block.
//               The top module header describes the SWITCH_DEBOUNCE_IRQ_EN build option.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package switch_pkg;

   localparam int          SW_BANKS         = 8;
   localparam int          SW_BANK_W        = 8;
   localparam int          DEBOUNCE_DEFAULT = 250000;
   // All switches off; the pins are active-low.
   localparam logic [7:0]  SW_IDLE          = 8'hFF;

   typedef logic [SW_BANK_W-1:0] bank_t;

endpackage : switch_pkg

`default_nettype wire

// File: rtl/switch_debounce_lane.sv
//==============================================================================
// Module      : switch_debounce_lane
// Description : One 8-bit switch bank. It has a 3-stage sync/history chain, a
//               debounce counter, a committed-value register and a commit pulse.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module switch_debounce_lane
   import switch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic  clk,
   input  logic  reset,
   input  bank_t raw,
   output bank_t stable,
   output logic  commit
);

   // Counter width is derived only; DEBOUNCE_CYCLES-1 always fits.
   localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   bank_t            s1;
   bank_t            s2;
   bank_t            s3;
   logic [CNT_W-1:0] cnt;
   logic             moving;
   logic             pending;
   logic             at_max;

   // s1/s2 form the synchroniser. s3 holds the previous synchronised sample,
   // so a change between s2 and s3 means the input is still moving.
   assign moving  = (s2 != s3);
   assign pending = (s2 != stable);
   assign at_max  = (cnt == CNT_MAX);
   assign commit  = !moving && pending && at_max;

   // Synchroniser and one-sample history; reset to the all-off pattern.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= SW_IDLE;
         s2 <= SW_IDLE;
         s3 <= SW_IDLE;
      end else begin
         s1 <= raw;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // The debounce counter runs while a differing value holds steady, and the
   // value is committed once the counter reaches the end of the window.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         stable <= SW_IDLE;
      end else if (moving || !pending) begin
         cnt    <= '0;
      end else if (at_max) begin
         stable <= s2;
         cnt    <= '0;
      end else begin
         cnt    <= cnt + CNT_W'(1);
      end
   end

endmodule : switch_debounce_lane

`default_nettype wire

// File: rtl/switch_debounce.sv
//==============================================================================
// Module      : switch_debounce
// Description : Debounces 8 banks of raw active-low DIP switches. The output
//               polarity is the same as the input polarity. An optional level
//               interrupt is raised when any bank commits a new value.
//               Build option: SWITCH_DEBOUNCE_IRQ_EN enables sw_irq and
//               sw_irq_ack. When the macro is not defined, sw_irq is held at 0.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module switch_debounce
   import switch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] dip_raw0,
   input  logic [7:0] dip_raw1,
   input  logic [7:0] dip_raw2,
   input  logic [7:0] dip_raw3,
   input  logic [7:0] dip_raw4,
   input  logic [7:0] dip_raw5,
   input  logic [7:0] dip_raw6,
   input  logic [7:0] dip_raw7,
   output logic [7:0] dip_switch0,
   output logic [7:0] dip_switch1,
   output logic [7:0] dip_switch2,
   output logic [7:0] dip_switch3,
   output logic [7:0] dip_switch4,
   output logic [7:0] dip_switch5,
   output logic [7:0] dip_switch6,
   output logic [7:0] dip_switch7,
   output logic       sw_irq,
   input  logic       sw_irq_ack
);

   bank_t               raw_bank    [SW_BANKS];
   bank_t               stable_bank [SW_BANKS];
   logic [SW_BANKS-1:0] commit_bank;
   logic                any_commit;

   assign raw_bank[0] = dip_raw0;
   assign raw_bank[1] = dip_raw1;
   assign raw_bank[2] = dip_raw2;
   assign raw_bank[3] = dip_raw3;
   assign raw_bank[4] = dip_raw4;
   assign raw_bank[5] = dip_raw5;
   assign raw_bank[6] = dip_raw6;
   assign raw_bank[7] = dip_raw7;

   assign dip_switch0 = stable_bank[0];
   assign dip_switch1 = stable_bank[1];
   assign dip_switch2 = stable_bank[2];
   assign dip_switch3 = stable_bank[3];
   assign dip_switch4 = stable_bank[4];
   assign dip_switch5 = stable_bank[5];
   assign dip_switch6 = stable_bank[6];
   assign dip_switch7 = stable_bank[7];

   genvar gi;
   generate
      for (gi = 0; gi < SW_BANKS; gi++) begin : g_lane
         switch_debounce_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .raw    (raw_bank[gi]),
            .stable (stable_bank[gi]),
            .commit (commit_bank[gi])
         );
      end
   endgenerate

   // Several banks can commit on the same edge. This is a single event for the interrupt.
   assign any_commit = |commit_bank;

`ifdef SWITCH_DEBOUNCE_IRQ_EN
   logic irq_flag;

   // Level interrupt. A commit sets it and an ack clears it. If both happen on
   // the same edge, the set has priority so that the new commit is not lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_flag <= 1'b0;
      end else if (any_commit) begin
         irq_flag <= 1'b1;
      end else if (sw_irq_ack) begin
         irq_flag <= 1'b0;
      end
   end

   assign sw_irq = irq_flag;
`else
   // The interrupt is disabled. The ports stay so the parent does not change.
   logic unused_irq_inputs;
   assign unused_irq_inputs = sw_irq_ack ^ any_commit;
   assign sw_irq            = 1'b0;
`endif

endmodule : switch_debounce

`default_nettype wire

// File: tb/tb_switch_debounce.sv
//==============================================================================
// Module      : tb_switch_debounce
// Description : Self-checking bench for switch_debounce with DEBOUNCE_CYCLES=4.
//               A run-length reference model checks every cycle. Literal
//               expectations pin the edge counts, reset and irq behaviour.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_switch_debounce;

   localparam int DC = 4;
`ifdef SWITCH_DEBOUNCE_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       ack   = 1'b0;
   logic [7:0] raw [8];
   logic [7:0] sw  [8];
   logic       irq;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   switch_debounce #(.DEBOUNCE_CYCLES(DC)) dut (
      .clk         (clk),
      .reset       (reset),
      .dip_raw0    (raw[0]),
      .dip_raw1    (raw[1]),
      .dip_raw2    (raw[2]),
      .dip_raw3    (raw[3]),
      .dip_raw4    (raw[4]),
      .dip_raw5    (raw[5]),
      .dip_raw6    (raw[6]),
      .dip_raw7    (raw[7]),
      .dip_switch0 (sw[0]),
      .dip_switch1 (sw[1]),
      .dip_switch2 (sw[2]),
      .dip_switch3 (sw[3]),
      .dip_switch4 (sw[4]),
      .dip_switch5 (sw[5]),
      .dip_switch6 (sw[6]),
      .dip_switch7 (sw[7]),
      .sw_irq      (irq),
      .sw_irq_ack  (ack)
   );

   // Reference model. A bank commits when the pin value seen two edges
   // earlier has been the same for DC+1 consecutive samples and differs
   // from the committed value.
   logic [63:0] hist [$];
   logic [7:0]  run_val [8];
   int          run_len [8];
   logic [7:0]  m_out [8];
   logic        m_irq;

   task automatic model_reset();
      hist.delete();
      hist.push_back({64{1'b1}});
      hist.push_back({64{1'b1}});
      for (int b = 0; b < 8; b++) begin
         run_val[b] = 8'hFF;
         run_len[b] = 2;
         m_out[b]   = 8'hFF;
      end
      m_irq = 1'b0;
   endtask

   task automatic model_edge();
      logic [63:0] pins;
      logic [63:0] seen;
      logic [7:0]  v;
      bit          any;
      for (int b = 0; b < 8; b++) pins[b*8 +: 8] = raw[b];
      hist.push_back(pins);
      while (hist.size() > 3) void'(hist.pop_front());
      seen = hist[0];
      any  = 1'b0;
      for (int b = 0; b < 8; b++) begin
         v = seen[b*8 +: 8];
         if (v == run_val[b]) begin
            if (run_len[b] < 1000) run_len[b]++;
         end else begin
            run_val[b] = v;
            run_len[b] = 1;
         end
         if (run_len[b] >= DC + 1 && v != m_out[b]) begin
            m_out[b] = v;
            any      = 1'b1;
         end
      end
      if (!IRQ_ON)   m_irq = 1'b0;
      else if (any)  m_irq = 1'b1;
      else if (ack)  m_irq = 1'b0;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge reset);
         if (reset) model_reset();
         else       model_edge();
      end
   end

   // Per-cycle compare process, sampling on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            for (int b = 0; b < 8; b++) begin
               checks++;
               if (sw[b] !== m_out[b]) begin
                  errors++;
                  $display("FAIL model_sw%0d t=%0t actual %h required %h", b, $time, sw[b], m_out[b]);
               end
            end
            checks++;
            if (irq !== m_irq) begin
               errors++;
               $display("FAIL model_irq t=%0t actual %b required %b", $time, irq, m_irq);
            end
         end
      end
   end

   task automatic expect_val(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual %h required %h", name, $time, act, exp);
      end
   endtask

   task automatic ack_pulse();
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
   endtask

   initial begin
      for (int b = 0; b < 8; b++) raw[b] = 8'hFF;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      for (int b = 0; b < 8; b++) expect_val($sformatf("reset_sw%0d", b), sw[b], 8'hFF);
      expect_val("reset_irq", {7'd0, irq}, 8'h00);
      reset  = 1'b0;
      cmp_en = 1'b1;
      repeat (3) @(negedge clk);

      // Single bank change: visible after edge 7, not edge 6.
      raw[2] = 8'hFE;
      repeat (6) @(negedge clk);
      expect_val("t2_edge6_sw2", sw[2], 8'hFF);
      expect_val("t2_edge6_irq", {7'd0, irq}, 8'h00);
      @(negedge clk);
      expect_val("t2_edge7_sw2", sw[2], 8'hFE);
      expect_val("t2_edge7_sw3", sw[3], 8'hFF);
      expect_val("t2_edge7_irq", {7'd0, irq}, {7'd0, IRQ_ON});
      ack_pulse();
      expect_val("t5_ack_clear", {7'd0, irq}, 8'h00);

      // Bounce shorter than the window never propagates.
      for (int i = 0; i < 20; i++) begin
         raw[5] = ((i / 2) % 2 == 0) ? 8'h7F : 8'hFF;
         @(negedge clk);
      end
      raw[5] = 8'hFF;
      repeat (10) @(negedge clk);
      expect_val("t3_sw5", sw[5], 8'hFF);
      expect_val("t3_irq", {7'd0, irq}, 8'h00);

      // Two banks change on the same cycle and commit together.
      raw[0] = 8'h00;
      raw[7] = 8'h0F;
      repeat (6) @(negedge clk);
      expect_val("t4_edge6_sw0", sw[0], 8'hFF);
      @(negedge clk);
      expect_val("t4_edge7_sw0", sw[0], 8'h00);
      expect_val("t4_edge7_sw7", sw[7], 8'h0F);
      expect_val("t4_irq", {7'd0, irq}, {7'd0, IRQ_ON});
      ack_pulse();
      expect_val("t4_ack_clear", {7'd0, irq}, 8'h00);

      // An ack on the same edge as a new commit: the set has priority.
      raw[1] = 8'hAA;
      repeat (6) @(negedge clk);
      ack_pulse();
      expect_val("t5_coincide_sw1", sw[1], 8'hAA);
      expect_val("t5_coincide_irq", {7'd0, irq}, {7'd0, IRQ_ON});

      // A mid-cycle reset clears the outputs immediately.
      #2 reset = 1'b1;
      #1;
      for (int b = 0; b < 8; b++) expect_val($sformatf("midrst_sw%0d", b), sw[b], 8'hFF);
      expect_val("midrst_irq", {7'd0, irq}, 8'h00);
      @(negedge clk);
      reset = 1'b0;

      // Random phase: sparse bank changes, single-bit bounces, reverts and acks.
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         for (int b = 0; b < 8; b++) begin
            case ($urandom_range(0, 15))
               0:       raw[b] = 8'($urandom);
               1:       raw[b] = raw[b] ^ 8'(1 << $urandom_range(0, 7));
               2:       raw[b] = m_out[b];
               default: ;
            endcase
         end
         ack = ($urandom_range(0, 7) == 0);
         if (n == 1500) begin
            #2 reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
         end
      end
      @(negedge clk);
      ack = 1'b0;
      repeat (12) @(negedge clk);
      cmp_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_switch_debounce

`default_nettype wire
